// File: rtl/board_pkg.sv
// Shared types and defaults for the ship board: cell encoding, controller states
// and the row/column to linear cell index helper.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        READY  = 2'd1,
        LOOKUP = 2'd2,
        ANSWER = 2'd3
    } state_t;

    localparam int BOARD_SIZE_DEF = 10;
    localparam int SHIP_CELLS_DEF = 10;

    // Callers range-check row and col first, so the 7-bit result never wraps.
    function automatic logic [6:0] cell_idx(input logic [3:0] row, input logic [3:0] col,
                                            input logic [3:0] size);
        return 7'(row) * 7'(size) + 7'(col);
    endfunction

endpackage

// File: rtl/ship_board_edge_det.sv
// Registered rising-edge detector for the pick_ship level; the pulse appears
// one cycle after the input rises.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            d_q    <= d_i;
            rise_q <= d_i & ~d_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/ship_board.sv
// One player's board: clear sweep, ship placement, shot answering and a VGA read port.
// Optional macro ADJ_CHECK_EN rejects placements touching an existing ship.
module ship_board
    import board_pkg::*;
#(
    parameter int BOARD_SIZE = BOARD_SIZE_DEF,
    parameter int SHIP_CELLS = SHIP_CELLS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       place_en,
    input  logic       pick_ship,
    input  logic [7:0] mouse_position,
    input  logic       shot_valid,
    input  logic [7:0] shot_pos,
    output logic       shot_ready,
    output logic       answer_valid,
    output logic       answer,
    input  logic [7:0] rd_pos,
    output cell_t      rd_cell,
    output logic [3:0] ship_count,
    output logic       ships_done,
    output logic [3:0] hits_taken,
    output logic       all_sunk,
    output logic       place_err,
    output logic       busy,
    output state_t     state_dbg
);

    localparam int         NCELLS   = BOARD_SIZE * BOARD_SIZE;
    localparam logic [6:0] LAST_IDX = 7'(NCELLS - 1);
    localparam logic [3:0] BS4      = 4'(BOARD_SIZE);
    localparam logic [3:0] SC4      = 4'(SHIP_CELLS);

    cell_t      board_q [NCELLS];
    state_t     state_q, state_d;
    logic [6:0] sweep_q, sweep_d;
    logic [7:0] shot_pos_q, shot_pos_d;
    logic [3:0] ship_count_q, ship_count_d, hits_q, hits_d;
    logic       place_err_q, place_err_d, answer_valid_q, answer_valid_d, answer_q, answer_d;
    logic       ships_done_q, all_sunk_q, busy_q;
    cell_t      rd_cell_q;
    logic       wr_en;
    logic [6:0] wr_idx;
    cell_t      wr_cell;
    logic       pick_rise, adj_ship, place_ok;
    cell_t      place_cell, shot_cell;

    function automatic logic in_range(input logic [7:0] pos);
        return (pos[7:4] < BS4) && (pos[3:0] < BS4);
    endfunction

    edge_det u_pick_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pick_ship),
        .rise_o(pick_rise)
    );

    assign place_cell = in_range(mouse_position)
                      ? board_q[cell_idx(mouse_position[7:4], mouse_position[3:0], BS4)] : EMPTY;
    assign shot_cell  = in_range(shot_pos_q)
                      ? board_q[cell_idx(shot_pos_q[7:4], shot_pos_q[3:0], BS4)] : EMPTY;

`ifdef ADJ_CHECK_EN
    // Neighbours that fall off the board are skipped by the bounds terms.
    always_comb begin
        adj_ship = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((dr != 0 || dc != 0)
                    && (int'(mouse_position[7:4]) + dr >= 0)
                    && (int'(mouse_position[7:4]) + dr < BOARD_SIZE)
                    && (int'(mouse_position[3:0]) + dc >= 0)
                    && (int'(mouse_position[3:0]) + dc < BOARD_SIZE)
                    && (board_q[7'((int'(mouse_position[7:4]) + dr) * BOARD_SIZE
                                   + int'(mouse_position[3:0]) + dc)] == SHIP)) begin
                    adj_ship = 1'b1;
                end
            end
        end
    end
`else
    assign adj_ship = 1'b0;
`endif

    assign place_ok = (state_q == READY) && place_en && !clear && in_range(mouse_position)
                    && (place_cell == EMPTY) && (ship_count_q < SC4) && !adj_ship;

    assign shot_ready = (state_q == READY) && !place_en;

    always_comb begin
        state_d        = state_q;
        sweep_d        = sweep_q;
        shot_pos_d     = shot_pos_q;
        ship_count_d   = ship_count_q;
        hits_d         = hits_q;
        answer_d       = answer_q;
        answer_valid_d = 1'b0;
        place_err_d    = pick_rise && !place_ok;
        wr_en          = 1'b0;
        wr_idx         = sweep_q;
        wr_cell        = EMPTY;
        if (clear) begin
            state_d      = CLEAR;
            sweep_d      = '0;
            ship_count_d = '0;
            hits_d       = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    wr_en        = 1'b1;
                    ship_count_d = '0;
                    hits_d       = '0;
                    if (sweep_q == LAST_IDX) begin
                        sweep_d = '0;
                        state_d = READY;
                    end else begin
                        sweep_d = sweep_q + 7'd1;
                    end
                end
                READY: begin
                    if (pick_rise && place_ok) begin
                        wr_en        = 1'b1;
                        wr_idx       = cell_idx(mouse_position[7:4], mouse_position[3:0], BS4);
                        wr_cell      = SHIP;
                        ship_count_d = ship_count_q + 4'd1;
                    end
                    if (shot_valid && shot_ready) begin
                        shot_pos_d = shot_pos;
                        state_d    = LOOKUP;
                    end
                end
                LOOKUP: begin
                    state_d        = ANSWER;
                    answer_valid_d = 1'b1;
                    answer_d       = 1'b0;
                    wr_idx         = cell_idx(shot_pos_q[7:4], shot_pos_q[3:0], BS4);
                    if (in_range(shot_pos_q) && shot_cell == SHIP) begin
                        wr_en    = 1'b1;
                        wr_cell  = HIT;
                        answer_d = 1'b1;
                        hits_d   = hits_q + 4'd1;
                    end else if (in_range(shot_pos_q) && shot_cell == EMPTY) begin
                        wr_en   = 1'b1;
                        wr_cell = MISS;
                    end
                end
                default: state_d = READY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= CLEAR;
            sweep_q        <= '0;
            shot_pos_q     <= '0;
            ship_count_q   <= '0;
            hits_q         <= '0;
            answer_q       <= 1'b0;
            answer_valid_q <= 1'b0;
            place_err_q    <= 1'b0;
            ships_done_q   <= 1'b0;
            all_sunk_q     <= 1'b0;
            busy_q         <= 1'b0;
            rd_cell_q      <= EMPTY;
        end else begin
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            shot_pos_q     <= shot_pos_d;
            ship_count_q   <= ship_count_d;
            hits_q         <= hits_d;
            answer_q       <= answer_d;
            answer_valid_q <= answer_valid_d;
            place_err_q    <= place_err_d;
            ships_done_q   <= (ship_count_d == SC4);
            all_sunk_q     <= (ship_count_d == SC4) && (hits_d == ship_count_d);
            busy_q         <= (state_d == CLEAR);
            rd_cell_q      <= (state_q == CLEAR || !in_range(rd_pos))
                            ? EMPTY : board_q[cell_idx(rd_pos[7:4], rd_pos[3:0], BS4)];
        end
    end

    // Storage is never reset: the CLEAR sweep initialises it and rd_cell is masked meanwhile.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            board_q[wr_idx] <= wr_cell;
        end
    end

    assign answer_valid = answer_valid_q;
    assign answer       = answer_q;
    assign rd_cell      = rd_cell_q;
    assign ship_count   = ship_count_q;
    assign ships_done   = ships_done_q;
    assign hits_taken   = hits_q;
    assign all_sunk     = all_sunk_q;
    assign place_err    = place_err_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ship_board.sv
// Directed bench for ship_board: reset sweep, placement and rejects, shots,
// sinking, clear abort and the ADJ_CHECK_EN neighbour rule.
module tb_ship_board;
    import board_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       place_en = 1'b0;
    logic       pick_ship = 1'b0;
    logic [7:0] mouse_position = '0;
    logic       shot_valid = 1'b0;
    logic [7:0] shot_pos = '0;
    logic [7:0] rd_pos = '0;
    logic       shot_ready, answer_valid, answer, ships_done, all_sunk, place_err, busy;
    logic [3:0] ship_count, hits_taken;
    cell_t      rd_cell;
    state_t     state_dbg;

    int          vectors = 0;
    int          miscompares = 0;
    int          av_count = 0;
    int          av_before = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  ship_tab[10];

    ship_board dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .place_en      (place_en),
        .pick_ship     (pick_ship),
        .mouse_position(mouse_position),
        .shot_valid    (shot_valid),
        .shot_pos      (shot_pos),
        .shot_ready    (shot_ready),
        .answer_valid  (answer_valid),
        .answer        (answer),
        .rd_pos        (rd_pos),
        .rd_cell       (rd_cell),
        .ship_count    (ship_count),
        .ships_done    (ships_done),
        .hits_taken    (hits_taken),
        .all_sunk      (all_sunk),
        .place_err     (place_err),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while ((busy || state_dbg != READY) && i < budget) begin
            tick();
            i++;
        end
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic place(input logic [7:0] pos, input logic exp_err, input logic [3:0] exp_cnt);
        mouse_position = pos;
        pick_ship = 1'b1;
        tick();
        pick_ship = 1'b0;
        tick();
        check("place_err", 32'(place_err), 32'(exp_err));
        check("ship_count", 32'(ship_count), 32'(exp_cnt));
        tick();
        check("place_err_pulse", 32'(place_err), 32'd0);
    endtask

    task automatic read_cell(input logic [7:0] pos, input cell_t exp);
        rd_pos = pos;
        tick();
        check("rd_cell", 32'(rd_cell), 32'(exp));
    endtask

    task automatic shoot(input logic [7:0] pos, input logic exp_ans);
        int i = 0;
        while (!shot_ready && i < 20) begin
            tick();
            i++;
        end
        check("shot_ready", 32'(shot_ready), 32'd1);
        shot_pos = pos;
        shot_valid = 1'b1;
        exp_q.push_back(32'(exp_ans));
        tick();
        shot_valid = 1'b0;
        check("av_lookup", 32'(answer_valid), 32'd0);
        tick();
        check("av_pulse", 32'(answer_valid), 32'd1);
        check("answer", 32'(answer), 32'(exp_ans));
        tick();
        check("av_drop", 32'(answer_valid), 32'd0);
        check("answer_hold", 32'(answer), 32'(exp_ans));
    endtask

    // scoreboard: every answer_valid pulse consumes one expected answer
    always @(negedge clk) begin
        if (rst_n && answer_valid) begin
            av_count++;
            if (exp_q.size() == 0) check("ans_unexpected", 32'd1, 32'd0);
            else                   check("ans_sb", 32'(answer), exp_q.pop_front());
        end
    end

    initial begin
`ifdef ADJ_CHECK_EN
        ship_tab = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h20, 8'h22, 8'h24, 8'h26, 8'h28};
`else
        ship_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
`endif
        // reset
        tick_n(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_shot_ready", 32'(shot_ready), 32'd0);
        check("rst_av", 32'(answer_valid), 32'd0);
        check("rst_count", 32'(ship_count), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(CLEAR));
        rst_n = 1'b1;
        tick_n(5);
        check("sweep_busy", 32'(busy), 32'd1);
        wait_idle(200);
        check("idle_shot_ready", 32'(shot_ready), 32'd1);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++)
                read_cell({4'(r), 4'(c)}, EMPTY);
        read_cell(8'hAA, EMPTY);

        // placement and rejects
        place_en = 1'b1;
        tick();
        check("place_shot_ready", 32'(shot_ready), 32'd0);
        for (int i = 0; i < 9; i++) place(ship_tab[i], 1'b0, 4'(i + 1));
        place(ship_tab[3], 1'b1, 4'd9);
        place(8'hA0, 1'b1, 4'd9);
        place(ship_tab[9], 1'b0, 4'd10);
        check("ships_done", 32'(ships_done), 32'd1);
        place(8'h50, 1'b1, 4'd10);
        place_en = 1'b0;
        place(8'h60, 1'b1, 4'd10);
        read_cell(ship_tab[5], SHIP);
        read_cell(8'h0A, EMPTY);
        check("not_sunk", 32'(all_sunk), 32'd0);

        // shots
        shoot(ship_tab[2], 1'b1);
        check("hits_1", 32'(hits_taken), 32'd1);
        shoot(ship_tab[2], 1'b0);
        check("hits_repeat", 32'(hits_taken), 32'd1);
        shoot(8'h55, 1'b0);
        read_cell(8'h55, MISS);
        read_cell(ship_tab[2], HIT);
        shoot(8'hAA, 1'b0);
        check("hits_oob", 32'(hits_taken), 32'd1);
        check("sunk_early", 32'(all_sunk), 32'd0);

        // sinking
        for (int i = 0; i < 10; i++)
            if (i != 2) shoot(ship_tab[i], 1'b1);
        check("hits_all", 32'(hits_taken), 32'd10);
        check("all_sunk", 32'(all_sunk), 32'd1);

        // clear during LOOKUP aborts the shot
        av_before = av_count;
        shot_pos = 8'h77;
        shot_valid = 1'b1;
        tick();
        shot_valid = 1'b0;
        check("abort_state", 32'(state_dbg), 32'(LOOKUP));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_av", 32'(answer_valid), 32'd0);
        check("abort_count", 32'(ship_count), 32'd0);
        check("abort_hits", 32'(hits_taken), 32'd0);
        check("abort_done", 32'(ships_done), 32'd0);
        check("abort_sunk", 32'(all_sunk), 32'd0);
        tick_n(3);
        check("abort_no_answer", 32'(av_count), 32'(av_before));
        wait_idle(200);
        read_cell(8'h77, EMPTY);
        read_cell(ship_tab[2], EMPTY);

        // neighbour rule
        place_en = 1'b1;
        tick();
        place(8'h33, 1'b0, 4'd1);
`ifdef ADJ_CHECK_EN
        place(8'h44, 1'b1, 4'd1);
        read_cell(8'h44, EMPTY);
`else
        place(8'h44, 1'b0, 4'd2);
        read_cell(8'h44, SHIP);
`endif
        place_en = 1'b0;
        tick_n(2);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ship_board.md
SHIP_BOARD -- requirements
Module: ship_board

Interface
REQ-001 Parameter BOARD_SIZE, default 10, gives the cells per row and per column.
REQ-002 Parameter SHIP_CELLS, default 10, gives the ship cells per player.
REQ-003 Port clk, input, 1 bit: the single clock; every register is in this domain.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port clear, input, 1 bit: synchronous request to start a new game.
REQ-006 Port place_en, input, 1 bit: high while the game FSM is in PICK_SHIP.
REQ-007 Port pick_ship, input, 1 bit: level placement request from the game FSM.
REQ-008 Port mouse_position, input, 8 bits: [7:4] is the row, [3:0] is the column.
REQ-009 Ports shot_valid (input, 1), shot_pos (input, 8) and shot_ready (output, 1): the incoming-shot handshake.
REQ-010 Ports answer_valid (output, 1) and answer (output, 1): the shot result, where 1 means hit.
REQ-011 Ports rd_pos (input, 8) and rd_cell (output, 2): the cell read port for the VGA draw stage.
REQ-012 Ports ship_count (output, 4) and ships_done (output, 1): placement progress.
REQ-013 Ports hits_taken (output, 4) and all_sunk (output, 1): damage progress.
REQ-014 Ports place_err (output, 1) and busy (output, 1): a placement-rejected pulse and a clearing indicator.

Function
REQ-015 Board cells SHALL be 2-bit cell_t values: EMPTY, SHIP, HIT or MISS.
REQ-016 The FSM SHALL have four states, CLEAR, READY, LOOKUP and ANSWER, with transitions as follows.
  - CLEAR to READY: after the sweep completes.
  - READY to LOOKUP: on a shot handshake.
  - LOOKUP to ANSWER: unconditionally.
  - ANSWER to READY: unconditionally.
  - clear in any state: go to CLEAR.
REQ-017 CLEAR SHALL write EMPTY to one cell per cycle, index 0 to BOARD_SIZE²-1, zero both counters, and hold busy=1 throughout.
REQ-018 Placement SHALL be triggered by the rising edge of pick_ship, detected one cycle after the level changes.
REQ-019 A placement SHALL be accepted only when all of the following hold: place_en=1, state READY, row<BOARD_SIZE, col<BOARD_SIZE, cell EMPTY, and ship_count<SHIP_CELLS.
REQ-020 An accepted placement SHALL write SHIP and increment ship_count, both visible one cycle after edge detection.
REQ-021 A placement edge that fails any condition SHALL produce a one-cycle place_err pulse at the same latency and leave the board and counters unchanged.
REQ-022 ships_done SHALL equal (ship_count==SHIP_CELLS) and be registered.
REQ-023 shot_ready SHALL be 1 only when state is READY and place_en=0.
REQ-024 A shot SHALL be accepted when shot_valid and shot_ready are both 1 in the same cycle, and shot_pos SHALL be captured in that cycle.
REQ-025 The shot result SHALL depend on the target cell as follows.
  - SHIP: cell becomes HIT, answer=1, hits_taken increments.
  - EMPTY: cell becomes MISS, answer=0.
  - HIT, MISS or out of range: board unchanged, answer=0.
REQ-026 answer_valid SHALL pulse for exactly one cycle, two cycles after acceptance, and answer SHALL hold its value until the next answer_valid.
REQ-027 all_sunk SHALL equal (hits_taken==ship_count) and also require ships_done=1.
REQ-028 rd_cell SHALL return the cell at rd_pos with one-cycle registered latency, and SHALL return EMPTY for an out-of-range rd_pos or while busy=1.
REQ-029 A board write SHALL be visible on rd_cell no later than two cycles after the write.
REQ-030 Row and column arithmetic SHALL be 4-bit unsigned, and the cell index SHALL be row*BOARD_SIZE+col computed at 7 bits, with no wrap-around.
REQ-031 clear asserted mid-LOOKUP or mid-ANSWER SHALL abort the shot with no answer_valid and no board write.

Reset
REQ-032 Asserting rst_n low SHALL immediately set the state to CLEAR, the sweep index to 0, and every output to 0.
REQ-033 On release of rst_n, the block SHALL run the full CLEAR sweep, then enter READY with busy=0.

Configuration
REQ-034 When ADJ_CHECK_EN is defined, a placement SHALL also be rejected with place_err if any of the 8 neighbouring cells is SHIP, excluding neighbours off the board.
REQ-035 When ADJ_CHECK_EN is undefined, only the conditions of REQ-019 apply.

Structure
REQ-036 cell_t, the state enum, BOARD_SIZE_DEF and SHIP_CELLS_DEF SHALL reside in a shared package, board_pkg.
REQ-037 The pick_ship rising-edge detector SHALL be the single sub-module edge_det.
REQ-038 Storage SHALL be a register array inside ship_board.

Verification
REQ-039 The bench SHALL cover the following directed scenarios.
  - Reset: release rst_n, then 100 cycles later expect busy=0, shot_ready=1 (place_en=0), and rd_cell=EMPTY everywhere.
  - Placement: place_en=1, pick_ship pulsed at positions 0x00..0x09. Expect ship_count=10, ships_done=1, and rd_cell(0x05)=SHIP.
  - Rejects: a duplicate pick at 0x03, a pick at 0xA0, and an 11th pick each give one place_err pulse and leave ship_count unchanged.
  - Shots: a shot at 0x02 gives answer_valid 2 cycles later with answer=1 and hits_taken=1. A repeat at 0x02 gives answer=0 and hits_taken=1. A shot at 0x55 gives answer=0 and cell MISS.
  - Sinking: shoot all 10 ships and expect all_sunk=1. Assert clear mid-LOOKUP and expect no answer_valid, busy=1, and counters at 0.
  - ADJ_CHECK_EN: a ship at 0x33 followed by a pick at 0x44 gives place_err; without the macro, the same pick is accepted.
